// File: rtl/rotating_word_display.sv
// rtl/rotating_word_display.sv - rotating 2-bit-code word on N seven-segment digits; optional IDLE blink via ROTATE_BLINK_EN
module rotating_word_display #(
    parameter int N_DIGITS = 6,
    parameter int TICK_DIV = 25000000,
    localparam int IDX_W   = $clog2(N_DIGITS)
) (
    input  logic                    CLOCK_50,
    input  logic                    Resetn,
    input  logic                    load_en,
    input  logic [IDX_W-1:0]        load_idx,
    input  logic [1:0]              load_char,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    dir,
    output logic [7*N_DIGITS-1:0]   hex,
    output logic [IDX_W-1:0]        offset,
    output logic                    running
);

    localparam int PS_W = $clog2(TICK_DIV);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t            state_q;
    logic              running_q;
    logic [IDX_W-1:0]  offset_q;
    logic [PS_W-1:0]   ps_q;
    logic [1:0]        word_q [N_DIGITS];
`ifdef ROTATE_BLINK_EN
    logic              blink_q;
`endif

    logic              ps_wrap;
    logic [IDX_W-1:0]  offset_inc;
    logic [IDX_W-1:0]  offset_dec;

    assign ps_wrap    = (ps_q == PS_W'(TICK_DIV - 1));
    assign offset_inc = (offset_q == IDX_W'(N_DIGITS - 1)) ? '0 : offset_q + 1'b1;
    assign offset_dec = (offset_q == '0) ? IDX_W'(N_DIGITS - 1) : offset_q - 1'b1;

    assign offset  = offset_q;
    assign running = running_q;

    // Segment pattern for a character code, bits g..a, active low.
    function automatic logic [6:0] decode(input logic [1:0] c);
        case (c)
            2'b00:   return 7'b0100001;
            2'b01:   return 7'b0000110;
            2'b10:   return 7'b1111001;
            default: return 7'b1111111;
        endcase
    endfunction

    // Word slot shown on digit k: (k + off) mod N_DIGITS without a divider.
    function automatic logic [IDX_W-1:0] slot(input int k, input logic [IDX_W-1:0] off);
        logic [IDX_W:0] s;
        s = (IDX_W+1)'(k) + {1'b0, off};
        if (s >= (IDX_W+1)'(N_DIGITS)) s = s - (IDX_W+1)'(N_DIGITS);
        return s[IDX_W-1:0];
    endfunction

    // Combinational digit mapping; blanking overrides everything while blinking.
    always_comb begin
        hex = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            hex[7*k +: 7] = decode(word_q[slot(k, offset_q)]);
        end
`ifdef ROTATE_BLINK_EN
        if (blink_q) hex = '1;
`endif
    end

    // IDLE/RUN control, word storage, prescaler and offset stepping.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
            offset_q  <= '0;
            ps_q      <= '0;
            for (int i = 0; i < N_DIGITS; i++) word_q[i] <= 2'b11;
`ifdef ROTATE_BLINK_EN
            blink_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_en && (32'(load_idx) < N_DIGITS)) word_q[load_idx] <= load_char;
                    if (start && !stop) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                        ps_q      <= '0;
`ifdef ROTATE_BLINK_EN
                        blink_q   <= 1'b0;
`endif
                    end else begin
`ifdef ROTATE_BLINK_EN
                        if (ps_wrap) begin
                            ps_q    <= '0;
                            blink_q <= ~blink_q;
                        end else begin
                            ps_q    <= ps_q + 1'b1;
                        end
`else
                        ps_q <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_q   <= S_IDLE;
                        running_q <= 1'b0;
                        ps_q      <= '0;
                    end else if (ps_wrap) begin
                        ps_q     <= '0;
                        offset_q <= dir ? offset_dec : offset_inc;
                    end else begin
                        ps_q <= ps_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
